// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody player and the keyboard-piano path.
//   - FSM state encoding for melody_sequencer
//   - SILENCE_DIV: the divisor note_gen treats as silence
//   - Note divisors for a 100 MHz clock: DIV_x = CLK_HZ / (2 * f) - 1
//   - Helper functions used to build the melody ROM
package melody_sequencer_pkg;

  localparam int DIV_W  = 22;
  localparam int CLK_HZ = 100_000_000;

  typedef logic [DIV_W-1:0] div_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam div_t SILENCE_DIV = 22'd1;

  localparam div_t DIV_C4 = div_t'(CLK_HZ / (2 * 262) - 1);
  localparam div_t DIV_D4 = div_t'(CLK_HZ / (2 * 294) - 1);
  localparam div_t DIV_E4 = div_t'(CLK_HZ / (2 * 330) - 1);
  localparam div_t DIV_F4 = div_t'(CLK_HZ / (2 * 349) - 1);
  localparam div_t DIV_G4 = div_t'(CLK_HZ / (2 * 392) - 1);
  localparam div_t DIV_A4 = div_t'(CLK_HZ / (2 * 440) - 1);
  localparam div_t DIV_B4 = div_t'(CLK_HZ / (2 * 494) - 1);
  localparam div_t DIV_C5 = div_t'(CLK_HZ / (2 * 523) - 1);

  // One octave up halves the divisor; a rest stays a rest.
  function automatic div_t octave_up(input div_t d);
    return (d == SILENCE_DIV) ? SILENCE_DIV : (d >> 1);
  endfunction

endpackage

// File: rtl/melody_sequencer_rom.sv
// melody_rom: combinational melody table.
//   beat_idx_i   beat index
//   div_left_o   left-channel divisor for that beat
//   div_right_o  right-channel divisor (left voice one octave up)
// The melody is a 16-step phrase repeated through the song; steps with no
// note are rests. Indices at or beyond SONG_LEN return silence.
module melody_rom
  import melody_sequencer_pkg::*;
#(
  parameter int IDX_W    = 6,
  parameter int SONG_LEN = 64
) (
  input  logic [IDX_W-1:0] beat_idx_i,
  output logic [21:0]      div_left_o,
  output logic [21:0]      div_right_o
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    div_left_o  = SILENCE_DIV;
    div_right_o = SILENCE_DIV;
    if (int'(beat_idx_i) < SONG_LEN) begin
      case (4'(beat_idx_i))
        4'd0:    div_left_o = DIV_C4;
        4'd1:    div_left_o = DIV_E4;
        4'd2:    div_left_o = DIV_G4;
        4'd4:    div_left_o = DIV_F4;
        4'd5:    div_left_o = DIV_A4;
        4'd6:    div_left_o = DIV_C5;
        4'd8:    div_left_o = DIV_G4;
        4'd9:    div_left_o = DIV_F4;
        4'd10:   div_left_o = DIV_E4;
        4'd11:   div_left_o = DIV_D4;
        4'd12:   div_left_o = DIV_C4;
        4'd13:   div_left_o = DIV_D4;
        4'd14:   div_left_o = DIV_C4;
        default: div_left_o = SILENCE_DIV;  // rests on steps 3, 7, 15
      endcase
      div_right_o = octave_up(div_left_o);
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through the melody ROM one note pair per beat and
// drives note_gen's divisors.
//   clk            system clock
//   rst            asynchronous active-low reset
//   play           pulse: start / pause / resume
//   stop           pulse: abort and rewind (wins over play)
//   loop_en        level: wrap to beat 0 after the last beat
//   tempo_sel      beat length = BEAT_DIV >> tempo_sel
//   note_div_left  left divisor, 22'd1 = silence
//   note_div_right right divisor, 22'd1 = silence
//   beat_idx       current beat
//   playing        high while playing
//   done           one-cycle pulse when a non-looping melody ends
// All outputs are registered and computed from next-state values, so they
// change on the same edge as the state, beat index and tick counter.
// GAP must stay below the shortest beat length in use.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int SONG_LEN = 64,
  parameter int IDX_W    = 6,
  parameter int BEAT_DIV = 25_000_000,
  parameter int GAP      = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [1:0]       tempo_sel,
  output logic [21:0]      note_div_left,
  output logic [21:0]      note_div_right,
  output logic [IDX_W-1:0] beat_idx,
  output logic             playing,
  output logic             done
);

  localparam int TICK_W = $clog2(BEAT_DIV + 1);
  localparam logic [TICK_W-1:0] BEAT_DIV_T = TICK_W'(BEAT_DIV);
  localparam logic [TICK_W-1:0] GAP_T      = TICK_W'(GAP);
  localparam logic [TICK_W-1:0] ONE_T      = TICK_W'(1);
  localparam logic [IDX_W-1:0]  ONE_IDX    = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(SONG_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W-1:0] beat_len_q, beat_len_d;
  logic [21:0]       left_q, left_d, right_q, right_d;
  logic              playing_q, done_q, done_d;

  logic [TICK_W-1:0] beat_len_new;
  logic              beat_end;
  logic              sounding;
  logic [21:0]       rom_left, rom_right;

  assign beat_len_new = BEAT_DIV_T >> tempo_sel;
  assign beat_end     = (tick_q == beat_len_q - ONE_T);

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    tick_d     = tick_q;
    beat_len_d = beat_len_q;
    done_d     = 1'b0;
    if (stop) begin
      state_d    = ST_IDLE;
      beat_idx_d = '0;
      tick_d     = '0;
      beat_len_d = beat_len_new;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            state_d    = ST_PLAY;
            beat_idx_d = '0;
            tick_d     = '0;
            beat_len_d = beat_len_new;
          end
        end
        ST_PLAY: begin
          if (play) begin
            state_d = ST_PAUSE;  // tick and beat freeze where they are
          end else if (beat_end) begin
            // Beat length is only re-sampled here, so a tempo change
            // mid-beat applies from the next beat.
            tick_d     = '0;
            beat_len_d = beat_len_new;
            if (beat_idx_q == LAST_IDX) begin
              beat_idx_d = '0;
              if (!loop_en) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              beat_idx_d = beat_idx_q + ONE_IDX;
            end
          end else begin
            tick_d = tick_q + ONE_T;
          end
        end
        ST_PAUSE: begin
          if (play) state_d = ST_PLAY;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  melody_rom #(
    .IDX_W    (IDX_W),
    .SONG_LEN (SONG_LEN)
  ) u_rom (
    .beat_idx_i  (beat_idx_d),
    .div_left_o  (rom_left),
    .div_right_o (rom_right)
  );

  // The last GAP ticks of every beat are silent so repeated notes articulate.
  assign sounding = (state_d == ST_PLAY) && (tick_d < beat_len_d - GAP_T);
  assign left_d   = sounding ? rom_left  : SILENCE_DIV;
  assign right_d  = sounding ? rom_right : SILENCE_DIV;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      tick_q     <= '0;
      beat_len_q <= BEAT_DIV_T;
      left_q     <= SILENCE_DIV;
      right_q    <= SILENCE_DIV;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      tick_q     <= tick_d;
      beat_len_q <= beat_len_d;
      left_q     <= left_d;
      right_q    <= right_d;
      playing_q  <= (state_d == ST_PLAY);
      done_q     <= done_d;
    end
  end

  assign note_div_left  = left_q;
  assign note_div_right = right_q;
  assign beat_idx       = beat_idx_q;
  assign playing        = playing_q;
  assign done           = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with a short 4-beat song,
// BEAT_DIV=16, GAP=4. Stimulus pushes expected output snapshots tagged with
// the cycle they must appear on; a monitor pops and compares them.
module tb_melody_sequencer;

  localparam int SONG_LEN = 4;
  localparam int IDX_W    = 6;
  localparam int BEAT_DIV = 16;
  localparam int GAP      = 4;

  // Hand-computed divisors: 100e6 / (2*f) - 1, right channel = left >> 1.
  localparam logic [21:0] S   = 22'd1;
  localparam logic [21:0] C4  = 22'd190838;
  localparam logic [21:0] C4R = 22'd95419;
  localparam logic [21:0] E4  = 22'd151514;
  localparam logic [21:0] E4R = 22'd75757;
  localparam logic [21:0] G4  = 22'd127550;
  localparam logic [21:0] G4R = 22'd63775;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             play = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [1:0]       tempo_sel = 2'd0;
  logic [21:0]      note_div_left, note_div_right;
  logic [IDX_W-1:0] beat_idx;
  logic             playing, done;

  melody_sequencer #(
    .SONG_LEN (SONG_LEN),
    .IDX_W    (IDX_W),
    .BEAT_DIV (BEAT_DIV),
    .GAP      (GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .play           (play),
    .stop           (stop),
    .loop_en        (loop_en),
    .tempo_sel      (tempo_sel),
    .note_div_left  (note_div_left),
    .note_div_right (note_div_right),
    .beat_idx       (beat_idx),
    .playing        (playing),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        pl;
    int          idx;
    logic [21:0] l;
    logic [21:0] r;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic pl, input int idx,
                               input logic [21:0] l, input logic [21:0] r, input logic dn);
    check({name, "/playing"}, 32'(playing), 32'(pl));
    check({name, "/beat_idx"}, 32'(beat_idx), 32'(idx));
    check({name, "/left"}, 32'(note_div_left), 32'(l));
    check({name, "/right"}, 32'(note_div_right), 32'(r));
    check({name, "/done"}, 32'(done), 32'(dn));
  endtask

  task automatic expect_at(input int c, input string nm, input logic pl, input int idx,
                           input logic [21:0] l, input logic [21:0] r, input logic dn);
    exp_t e;
    e.cyc = c; e.name = nm; e.pl = pl; e.idx = idx; e.l = l; e.r = r; e.dn = dn;
    sb.push_back(e);
  endtask

  // Monitor: one sample per cycle, 1 ns after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: sample missed, now cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
      end else begin
        check_outputs(e.name, e.pl, e.idx, e.l, e.r, e.dn);
      end
    end
  end

  // Called at a falling edge: waits until the given cycle count is reached.
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("in_reset", 1'b0, 0, S, S, 1'b0);
    rst = 1'b1;
    expect_at(cyc + 1, "idle_after_reset", 1'b0, 0, S, S, 1'b0);
    wait_cyc(cyc + 3);

    // Play from IDLE, non-looping run to the end.
    loop_en = 1'b0;
    t0 = cyc + 1;
    expect_at(t0,      "play_start",   1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 11, "before_gap",   1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 12, "gap_start",    1'b1, 0, S,  S,   1'b0);
    expect_at(t0 + 15, "gap_last",     1'b1, 0, S,  S,   1'b0);
    expect_at(t0 + 16, "beat1",        1'b1, 1, E4, E4R, 1'b0);
    expect_at(t0 + 32, "beat2",        1'b1, 2, G4, G4R, 1'b0);
    expect_at(t0 + 48, "beat3_rest",   1'b1, 3, S,  S,   1'b0);
    expect_at(t0 + 63, "last_tick",    1'b1, 3, S,  S,   1'b0);
    expect_at(t0 + 64, "done_pulse",   1'b0, 0, S,  S,   1'b1);
    expect_at(t0 + 65, "done_cleared", 1'b0, 0, S,  S,   1'b0);
    pulse_play();
    wait_cyc(t0 + 67);

    // Looping run, then stop and play together mid-beat.
    loop_en = 1'b1;
    t0 = cyc + 1;
    expect_at(t0,      "loop_start",  1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 63, "loop_last",   1'b1, 3, S,  S,   1'b0);
    expect_at(t0 + 64, "loop_wrap",   1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 65, "loop_nodone", 1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 69, "loop_tick5",  1'b1, 0, C4, C4R, 1'b0);
    expect_at(t0 + 70, "stop_wins",   1'b0, 0, S,  S,   1'b0);
    expect_at(t0 + 71, "stop_nodone", 1'b0, 0, S,  S,   1'b0);
    pulse_play();
    wait_cyc(t0 + 69);
    stop = 1'b1;
    play = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    play = 1'b0;
    wait_cyc(t0 + 73);
    loop_en = 1'b0;

    // Pause at tick 5 of beat 2, hold 100 cycles, resume.
    t0 = cyc + 1;
    expect_at(t0 + 37,  "pre_pause",   1'b1, 2, G4, G4R, 1'b0);
    expect_at(t0 + 38,  "paused",      1'b0, 2, S,  S,   1'b0);
    expect_at(t0 + 88,  "paused_mid",  1'b0, 2, S,  S,   1'b0);
    expect_at(t0 + 138, "paused_end",  1'b0, 2, S,  S,   1'b0);
    expect_at(t0 + 139, "resumed",     1'b1, 2, G4, G4R, 1'b0);
    expect_at(t0 + 149, "resume_gap",  1'b1, 2, S,  S,   1'b0);
    expect_at(t0 + 150, "resume_next", 1'b1, 3, S,  S,   1'b0);
    expect_at(t0 + 153, "stopped",     1'b0, 0, S,  S,   1'b0);
    pulse_play();
    wait_cyc(t0 + 37);
    pulse_play();
    wait_cyc(t0 + 138);
    pulse_play();
    wait_cyc(t0 + 152);
    pulse_stop();
    wait_cyc(t0 + 155);

    // Tempo change mid beat 0: beat 0 keeps 16 cycles, beat 1 gets 8.
    t0 = cyc + 1;
    expect_at(t0 + 15, "tempo_b0_end", 1'b1, 0, S,  S,   1'b0);
    expect_at(t0 + 16, "tempo_b1",     1'b1, 1, E4, E4R, 1'b0);
    expect_at(t0 + 19, "tempo_b1_t3",  1'b1, 1, E4, E4R, 1'b0);
    expect_at(t0 + 20, "tempo_b1_gap", 1'b1, 1, S,  S,   1'b0);
    expect_at(t0 + 23, "tempo_b1_t7",  1'b1, 1, S,  S,   1'b0);
    expect_at(t0 + 24, "tempo_b2",     1'b1, 2, G4, G4R, 1'b0);
    pulse_play();
    wait_cyc(t0 + 5);
    tempo_sel = 2'd1;
    wait_cyc(t0 + 25);
    pulse_stop();
    tempo_sel = 2'd0;
    wait_cyc(cyc + 2);

    // Asynchronous reset mid-beat silences outputs without a clock edge.
    t0 = cyc + 1;
    expect_at(t0 + 18, "pre_reset", 1'b1, 1, E4, E4R, 1'b0);
    pulse_play();
    wait_cyc(t0 + 18);
    #1 rst = 1'b0;
    #1 check_outputs("async_reset", 1'b0, 0, S, S, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    expect_at(cyc + 1, "after_async_reset", 1'b0, 0, S, S, 1'b0);
    wait_cyc(cyc + 3);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never sampled, expected at cycle %0d", e.name, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of note_gen: steps through a fixed melody stored in ROM, one note pair (left/right) per beat.
- Drives note_gen's note_div_left/note_div_right directly.
- Handles play/pause/stop, loop, tempo select, and a silent articulation gap at the end of every beat.
- Control inputs arrive as debounce+onepulse pulses from the board buttons.

Parameters:
- SONG_LEN, 64, number of beats in the melody; beat indices 0..SONG_LEN-1.
- IDX_W, 6, width of the beat index; must satisfy 2**IDX_W >= SONG_LEN.
- BEAT_DIV, 25000000, clk cycles per beat at tempo_sel=0 (0.25 s at 100 MHz).
- GAP, 1000000, clk cycles of forced silence at the end of each beat; must be < (BEAT_DIV>>3).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- play  in  1  single-cycle pulse; start / pause / resume toggle.
- stop  in  1  single-cycle pulse; abort and rewind.
- loop_en  in  1  level; when 1, the melody wraps to beat 0 after the last beat.
- tempo_sel  in  2  beat length = BEAT_DIV >> tempo_sel.
- note_div_left  out  22  divisor for the note_gen left channel; 22'd1 means silence.
- note_div_right  out  22  divisor for the note_gen right channel; 22'd1 means silence.
- beat_idx  out  IDX_W  current beat, for the seven-segment display.
- playing  out  1  high while in state PLAY.
- done  out  1  one-cycle pulse when a non-looping melody finishes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat_idx=0, tick_cnt=0.
  - note_div_left = note_div_right = 22'd1.
  - playing=0, done=0.
  - Reset mid-play silences the outputs immediately.
- All outputs are registered. They update on the same edge as state, beat_idx and tick_cnt.
- States: IDLE, PLAY, PAUSE.
  - IDLE + play -> PLAY, beat_idx=0, tick_cnt=0. On the next edge the outputs show ROM[0]; latency is 1 cycle after the play pulse is sampled.
  - PLAY + play -> PAUSE. tick_cnt and beat_idx are frozen; outputs become 22'd1.
  - PAUSE + play -> PLAY. Resumes at the frozen tick_cnt and beat_idx; outputs return to ROM[beat_idx], or silence if inside the gap.
  - Any state + stop -> IDLE, beat_idx=0, tick_cnt=0, outputs 22'd1, no done pulse.
  - stop and play in the same cycle: stop wins.
- Beat timing in PLAY:
  - beat_len = BEAT_DIV >> tempo_sel, held in a register that loads only at beat boundaries (tick_cnt wraps to 0), when play starts from IDLE, and on stop.
  - A tempo_sel change mid-beat therefore takes effect from the next beat.
  - tick_cnt counts 0..beat_len-1 and then wraps to 0.
- Beat boundary (tick_cnt == beat_len-1):
  - beat_idx < SONG_LEN-1: beat_idx increments.
  - beat_idx == SONG_LEN-1 and loop_en=1: beat_idx wraps to 0, state stays PLAY.
  - beat_idx == SONG_LEN-1 and loop_en=0: state -> IDLE, beat_idx=0, done=1 for exactly one cycle, outputs 22'd1.
  - loop_en is sampled only at the final beat boundary.
- Articulation gap: while tick_cnt >= beat_len-GAP, both outputs are 22'd1. Otherwise the outputs are the ROM entry for beat_idx.
- ROM rest entries are stored as 22'd1, so note_gen treats them as silence.
- playing = (state == PLAY).

Decomposition:
- Shared package holds:
  - state encoding constants.
  - SILENCE_DIV = 22'd1.
  - note divisor constants, e.g. DIV_C4 = 100_000_000/(2*262) - 1 and the rest of the scale, also used by the keyboard-piano path.
- Sub-module melody_rom:
  - combinational case from beat index [IDX_W-1:0] to {div_left[21:0], div_right[21:0]}.
  - indices >= SONG_LEN return SILENCE_DIV.

Test Plan:
- Play from IDLE (BEAT_DIV=16, GAP=4, SONG_LEN=4, tempo_sel=0, ROM[0]={DIV_C4, DIV_C4>>1}):
  - pulse play -> next cycle playing=1, beat_idx=0, note_div_left=DIV_C4.
  - 12 cycles after that, both outputs = 1.
  - at cycle 16, beat_idx=1.
- End without loop (loop_en=0):
  - after 64 cycles, done=1 for exactly one cycle.
  - playing=0, beat_idx=0, outputs=1.
- End with loop (loop_en=1):
  - at the same point beat_idx wraps 3->0, playing stays 1, done never asserts.
- Pause/resume:
  - play at tick 5 of beat 2 -> outputs 1, beat_idx=2 frozen for 100 cycles.
  - play again -> beat 2 ends 11 cycles later.
- Stop/play same cycle during PLAY:
  - state -> IDLE, beat_idx=0, no done pulse.
  - async reset asserted mid-beat -> outputs 1 with no clock edge.
- Tempo change:
  - tempo_sel 0->1 mid beat 0 -> beat 0 still lasts 16 cycles, beat 1 lasts 8.
  - gap in beat 1 starts at tick 4.
